// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: 8-position seven-segment scan sequencer (select, mux enable, active-low anodes).
// Latency: all outputs registered; en response is one cycle; rst_n clears outputs asynchronously.
// Backpressure: none; free-running scan while en=1, forced dark while en=0.
//
// Ports:
//   clk, rst_n     system clock (rising edge), asynchronous active-low reset
//   en             display enable; 0 forces OFF (dark, sel=0)
//   blink_mask     bit i=1 blinks position i (only with LED_SCAN_BLINK_EN defined)
//   sel            digit select to the 8:1 multiplexer
//   mux_en         multiplexer enable; 0 makes the mux emit blank code
//   an             digit anodes, active-low, one-hot-low or all-high
//   frame_tick     one-cycle pulse on the first GUARD cycle after sel wraps 7->0
//
// Optional feature macro: LED_SCAN_BLINK_EN (frame counter + blink phase).
// Each digit slot is GUARD all-off cycles followed by DIV lit cycles; frame = 8*(GUARD+DIV).

module led_scan_ctrl #(
  parameter int DIV          = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] blink_mask,
  output logic [2:0] sel,
  output logic       mux_en,
  output logic [7:0] an,
  output logic       frame_tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = $clog2(GUARD + 1);
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GLAST = GW'(GUARD - 1);

  typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_dcnt;
  logic [DW-1:0] w_dcnt_nxt;
  logic [GW-1:0] r_gcnt;
  logic [GW-1:0] w_gcnt_nxt;
  logic [2:0]    w_sel_nxt;
  logic          w_wrap;
  logic          w_blank;
  logic [7:0]    w_an_nxt;

  // Next-state logic. Outputs are derived from the next state so that
  // the registered outputs always describe the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_gcnt_nxt  = r_gcnt;
    w_sel_nxt   = sel;
    w_wrap      = 1'b0;
    if (!en) begin
      w_state_nxt = S_OFF;
      w_dcnt_nxt  = '0;
      w_gcnt_nxt  = '0;
      w_sel_nxt   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_GUARD;
          w_dcnt_nxt  = '0;
          w_gcnt_nxt  = '0;
          w_sel_nxt   = '0;
        end
        S_GUARD: begin
          if (r_gcnt == GLAST) begin
            w_state_nxt = S_ON;
            w_gcnt_nxt  = '0;
            w_dcnt_nxt  = '0;
          end else begin
            w_gcnt_nxt  = r_gcnt + 1'b1;
          end
        end
        S_ON: begin
          if (r_dcnt == DLAST) begin
            // sel advances on the same edge the anode goes dark
            w_state_nxt = S_GUARD;
            w_dcnt_nxt  = '0;
            w_gcnt_nxt  = '0;
            w_sel_nxt   = sel + 3'd1;
            w_wrap      = (sel == 3'd7);
          end else begin
            w_dcnt_nxt  = r_dcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_OFF;
          w_dcnt_nxt  = '0;
          w_gcnt_nxt  = '0;
          w_sel_nxt   = '0;
        end
      endcase
    end
  end

`ifdef LED_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_fcnt;
  logic          r_blink_phase;

  // Counts frame wraps; the phase flips every BLINK_FRAMES frames. It is
  // updated on the wrap edge, so it is settled before position 0 lights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else if (!en) begin
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_fcnt == FLAST) begin
        r_fcnt        <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_fcnt        <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_blank = r_blink_phase & blink_mask[w_sel_nxt];
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_blank        = 1'b0;
`endif

  assign w_an_nxt = ((w_state_nxt == S_ON) && !w_blank) ? ~(8'h01 << w_sel_nxt) : 8'hFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_OFF;
      r_dcnt     <= '0;
      r_gcnt     <= '0;
      sel        <= '0;
      mux_en     <= 1'b0;
      an         <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_gcnt     <= w_gcnt_nxt;
      sel        <= w_sel_nxt;
      mux_en     <= (w_state_nxt != S_OFF);
      an         <= w_an_nxt;
      frame_tick <= w_wrap;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: directed, table-driven bench for led_scan_ctrl.
// Latency: inputs driven on negedge, outputs compared on the following negedge.
// Backpressure: not applicable.

module tb_led_scan_ctrl;

  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int BF    = 2;
  localparam int SLOT  = GUARD + DIV;
  localparam int FRAME = 8 * SLOT;
  localparam int NTBL  = 6 * FRAME;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] blink_mask = 8'h00;
  logic [2:0] sel;
  logic       mux_en;
  logic [7:0] an;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       mux;
    logic [7:0] an;
    logic       ft;
  } vec_t;

  vec_t tbl [NTBL];

  led_scan_ctrl #(.DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .blink_mask (blink_mask),
    .sel        (sel),
    .mux_en     (mux_en),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [2:0] es,
                       input logic em, input logic [7:0] ea, input logic eft);
    checks++;
    if (sel !== es || mux_en !== em || an !== ea || frame_tick !== eft) begin
      errors++;
      $display("FAIL %s[%0d]: got sel=%0d mux_en=%b an=%h frame_tick=%b, want sel=%0d mux_en=%b an=%h frame_tick=%b",
               name, idx, sel, mux_en, an, frame_tick, es, em, ea, eft);
    end
  endtask

  // Expected scan, cycle c counted from the first GUARD cycle after enable.
  task automatic fill(input logic [7:0] mask, input bit blink);
    for (int c = 0; c < NTBL; c++) begin
      int f;
      int p;
      int d;
      int ph;
      f  = c / FRAME;
      p  = c % FRAME;
      d  = p / SLOT;
      ph = p % SLOT;
      tbl[c].en   = 1'b1;
      tbl[c].mask = mask;
      tbl[c].sel  = 3'(d);
      tbl[c].mux  = 1'b1;
      tbl[c].an   = (ph < GUARD) ? 8'hFF : ~(8'h01 << d);
      if (blink && ph >= GUARD && mask[d] && ((f / BF) % 2 == 1))
        tbl[c].an = 8'hFF;
      tbl[c].ft   = (p == 0) && (f > 0);
    end
  endtask

  task automatic run_table(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      en         = tbl[i].en;
      blink_mask = tbl[i].mask;
      @(negedge clk);
      check(name, i, tbl[i].sel, tbl[i].mux, tbl[i].an, tbl[i].ft);
    end
  endtask

  initial begin
    fill(8'h00, 1'b0);

    // Reset and idle
    @(negedge clk);
    check("reset", 0, 3'd0, 1'b0, 8'hFF, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle", i, 3'd0, 1'b0, 8'hFF, 1'b0);
    end

    // Three full frames, then into frame 4 up to the 2nd ON cycle of sel=3
    run_table("scan", 3 * FRAME + 3 * SLOT + GUARD + 2);

    // Mid-scan disable: one-cycle response to OFF
    en = 1'b0;
    @(negedge clk);
    check("disable", 0, 3'd0, 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    check("disable", 1, 3'd0, 1'b0, 8'hFF, 1'b0);

    // Re-enable: restart at sel=0 with no tick at entry, tick after one frame
    run_table("restart", FRAME + 5);

    // Async reset while an=FB
    en = 1'b0;
    @(negedge clk);
    run_table("pre_reset", 2 * SLOT + GUARD + 2);
    check("pre_reset_an", 0, 3'd2, 1'b1, 8'hFB, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 0, 3'd0, 1'b0, 8'hFF, 1'b0);
    #1 rst_n = 1'b1;
    en = 1'b0;
    @(negedge clk);
    check("post_reset_off", 0, 3'd0, 1'b0, 8'hFF, 1'b0);
    run_table("resume", SLOT + 2);

    // Blink over six frames
    en = 1'b0;
    @(negedge clk);
`ifdef LED_SCAN_BLINK_EN
    fill(8'h01, 1'b1);
`else
    fill(8'hFF, 1'b0);
`endif
    run_table("blink", NTBL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
